// File: rtl/rv32i_decode_stage_pkg.sv
// Shared RV32I decode types: instruction word, opcode map, immediate formats and the
// decoded packet carried from the decode stage to execute.
package rv32i_types;

    typedef logic [31:0] instr_t;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        fmt_i,
        fmt_s,
        fmt_b,
        fmt_u,
        fmt_j,
        fmt_r
    } imm_fmt_t;

    localparam logic [6:0] FUNCT7_BASE    = 7'b0000000;
    localparam logic [6:0] FUNCT7_VARIANT = 7'b0100000;
    localparam logic [2:0] F3_ADD         = 3'b000;
    localparam logic [2:0] F3_SLL         = 3'b001;
    localparam logic [2:0] F3_SR          = 3'b101;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        writes_rd;
        logic        illegal;
    } decode_pkt_t;

    localparam int PKT_W = $bits(decode_pkt_t);

    function automatic logic [31:0] gen_imm(input instr_t i, input imm_fmt_t fmt);
        logic [31:0] imm;
        case (fmt)
            fmt_i:   imm = {{20{i[31]}}, i[31:20]};
            fmt_s:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
            fmt_b:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            fmt_u:   imm = {i[31:12], 12'b0};
            fmt_j:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv32i_decode_stage_decoder.sv
// Pure combinational RV32I decoder: instruction word + PC in, decoded packet out.
// Illegal encodings still report their raw fields but never claim register usage.
module rv32i_decoder
    import rv32i_types::*;
#(
    parameter bit RD0_SUPPRESS = 1'b1
) (
    input  logic [31:0]      instr,
    input  logic [31:0]      pc,
    output logic [PKT_W-1:0] pkt
);

    decode_pkt_t dec;
    imm_fmt_t    fmt;
    logic        bad;
    logic        use1;
    logic        use2;
    logic        wr;
    logic        has_rd;
    logic [2:0]  f3;
    logic [6:0]  f7;

    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    always_comb begin
        fmt    = fmt_r;
        bad    = 1'b0;
        use1   = 1'b0;
        use2   = 1'b0;
        wr     = 1'b0;
        has_rd = 1'b1;
        case (instr[6:0])
            op_lui, op_auipc: begin
                fmt = fmt_u;
                wr  = 1'b1;
            end
            op_jal: begin
                fmt = fmt_j;
                wr  = 1'b1;
            end
            op_jalr: begin
                fmt  = fmt_i;
                use1 = 1'b1;
                wr   = 1'b1;
                bad  = (f3 != F3_ADD);
            end
            op_br: begin
                fmt    = fmt_b;
                use1   = 1'b1;
                use2   = 1'b1;
                has_rd = 1'b0;
                bad    = (f3[2:1] == 2'b01);
            end
            op_load: begin
                fmt  = fmt_i;
                use1 = 1'b1;
                wr   = 1'b1;
                bad  = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            op_store: begin
                fmt    = fmt_s;
                use1   = 1'b1;
                use2   = 1'b1;
                has_rd = 1'b0;
                bad    = (f3 > 3'b010);
            end
            op_imm: begin
                fmt  = fmt_i;
                use1 = 1'b1;
                wr   = 1'b1;
                bad  = ((f3 == F3_SLL) && (f7 != FUNCT7_BASE)) ||
                       ((f3 == F3_SR) && (f7 != FUNCT7_BASE) && (f7 != FUNCT7_VARIANT));
            end
            op_reg: begin
                fmt  = fmt_r;
                use1 = 1'b1;
                use2 = 1'b1;
                wr   = 1'b1;
                bad  = !((f7 == FUNCT7_BASE) ||
                         ((f7 == FUNCT7_VARIANT) && ((f3 == F3_ADD) || (f3 == F3_SR))));
            end
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        dec           = '0;
        dec.pc        = pc;
        dec.opcode    = instr[6:0];
        dec.funct3    = f3;
        dec.funct7    = f7;
        dec.rd        = has_rd ? instr[11:7] : 5'd0;
        dec.rs1       = instr[19:15];
        dec.rs2       = instr[24:20];
        dec.imm       = gen_imm(instr, fmt);
        dec.uses_rs1  = use1 && !bad;
        dec.uses_rs2  = use2 && !bad;
        // x0 is hardwired, so a write to it is reported as no write at all
        dec.writes_rd = wr && !bad && !(RD0_SUPPRESS && (instr[11:7] == 5'd0));
        dec.illegal   = bad;
    end

    assign pkt = dec;

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: decodes at the input and holds packets in an output register
// plus an optional skid entry so upstream sees a registered ready.
module rv32i_decode_stage
    import rv32i_types::*;
#(
    parameter bit SKID_EN      = 1'b1,
    parameter bit RD0_SUPPRESS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PKT_W-1:0] out_pkt
);

    logic [PKT_W-1:0] dec_pkt;
    logic [PKT_W-1:0] skid_pkt;
    logic             skid_valid;
    logic             accept;
    logic             out_load;

    rv32i_decoder #(
        .RD0_SUPPRESS(RD0_SUPPRESS)
    ) u_decoder (
        .instr(in_instr),
        .pc   (in_pc),
        .pkt  (dec_pkt)
    );

    assign in_ready = SKID_EN ? !skid_valid : (out_ready || !out_valid);
    assign accept   = in_valid && in_ready;
    assign out_load = !out_valid || out_ready;

    // The skid entry is always older than anything arriving, so it refills the output first
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pkt    <= '0;
            skid_valid <= 1'b0;
            skid_pkt   <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_load) begin
            if (skid_valid) begin
                out_pkt    <= skid_pkt;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_pkt   <= dec_pkt;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (SKID_EN && accept) begin
            skid_pkt   <= dec_pkt;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for the RV32I decode stage: directed scenarios plus a randomized run, all
// checked against an arithmetic decode model and a queue of in-flight packets.
module tb_rv32i_decode_stage;
    import rv32i_types::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [PKT_W-1:0] out_pkt;

    int tests_run    = 0;
    int tests_failed = 0;

    decode_pkt_t model_q[$];

    always #5 clk = ~clk;

    rv32i_decode_stage #(
        .SKID_EN     (1'b1),
        .RD0_SUPPRESS(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_instr (in_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pkt  (out_pkt)
    );

    // Decode from the ISA rules using shifts, masks and signed arithmetic
    function automatic decode_pkt_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        decode_pkt_t p;
        longint w, sgn, imm, op, f3, f7, rd;
        bit bad, u1, u2, wr, has_rd;
        w = longint'(ins);
        op = w & 'h7f; f3 = (w >> 12) & 7; f7 = (w >> 25) & 'h7f; rd = (w >> 7) & 31;
        sgn = (w >> 31) & 1;
        bad = 0; u1 = 0; u2 = 0; wr = 0; has_rd = 1; imm = 0;
        case (op)
            'h37, 'h17: begin imm = w & 'hFFFFF000; wr = 1; end
            'h6f: begin
                imm = ((w >> 12) & 'hff) * 4096 + ((w >> 20) & 1) * 2048
                      + ((w >> 21) & 'h3ff) * 2 - sgn * (1 << 20);
                wr = 1;
            end
            'h67: begin imm = ((w >> 20) & 'hfff) - sgn * 4096; u1 = 1; wr = 1; bad = (f3 != 0); end
            'h63: begin
                imm = ((w >> 7) & 1) * 2048 + ((w >> 25) & 'h3f) * 32 + ((w >> 8) & 'hf) * 2 - sgn * 4096;
                u1 = 1; u2 = 1; has_rd = 0; bad = (f3 == 2 || f3 == 3);
            end
            'h03: begin imm = ((w >> 20) & 'hfff) - sgn * 4096; u1 = 1; wr = 1; bad = (f3 == 3 || f3 >= 6); end
            'h23: begin
                imm = ((w >> 25) & 'h7f) * 32 + ((w >> 7) & 31) - sgn * 4096;
                u1 = 1; u2 = 1; has_rd = 0; bad = (f3 > 2);
            end
            'h13: begin
                imm = ((w >> 20) & 'hfff) - sgn * 4096; u1 = 1; wr = 1;
                bad = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 'h20);
            end
            'h33: begin
                u1 = 1; u2 = 1; wr = 1;
                bad = !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
            end
            default: bad = 1;
        endcase
        p = '0;
        p.pc        = pc;
        p.opcode    = 7'(op);
        p.funct3    = 3'(f3);
        p.funct7    = 7'(f7);
        p.rd        = has_rd ? 5'(rd) : 5'd0;
        p.rs1       = 5'((w >> 15) & 31);
        p.rs2       = 5'((w >> 20) & 31);
        p.imm       = imm[31:0];
        p.uses_rs1  = u1 && !bad;
        p.uses_rs2  = u2 && !bad;
        p.writes_rd = wr && !bad && (rd != 0);
        p.illegal   = bad;
        return p;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom();
        k = $urandom_range(0, 9);
        case (k)
            0: w[6:0] = 7'h37;
            1: w[6:0] = 7'h17;
            2: w[6:0] = 7'h6f;
            3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h03;
            6: w[6:0] = 7'h23;
            7: w[6:0] = 7'h13;
            8: w[6:0] = 7'h33;
            default: ;
        endcase
        if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return w;
    endfunction

    // Drive one cycle at the falling edge and advance the occupancy model accordingly
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        bit acc, fire;
        in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        acc  = iv && (model_q.size() < 2);
        fire = (model_q.size() > 0) && ordy;
        if (rst || fl) begin
            model_q.delete();
        end else begin
            if (fire) void'(model_q.pop_front());
            if (acc) model_q.push_back(ref_decode(ins, pc));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_instr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        tests_run++;
        if (out_pkt !== '0) begin
            tests_failed++; $display("[TB] FAIL reset_out_pkt got=%h exp=0", out_pkt);
        end
        rst = 1'b0;
        model_q.delete();
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_addi();
        decode_pkt_t got;
        step(1'b1, 32'h00500093, 32'h0000_1000, 1'b1, 1'b0);
        got = out_pkt;
        tests_run++;
        if (out_valid !== 1'b1 || got.rd !== 5'd1 || got.rs1 !== 5'd0 || got.imm !== 32'h5 ||
            got.writes_rd !== 1'b1 || got.uses_rs2 !== 1'b0 || got.illegal !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL addi got valid=%b rd=%0d rs1=%0d imm=%h wr=%b u2=%b ill=%b exp 1/1/0/00000005/1/0/0",
                     out_valid, got.rd, got.rs1, got.imm, got.writes_rd, got.uses_rs2, got.illegal);
        end
        tests_run++;
        if (out_pkt !== model_q[0]) begin
            tests_failed++; $display("[TB] FAIL addi_pkt got=%h exp=%h", out_pkt, model_q[0]);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_beq_lui();
        decode_pkt_t got;
        step(1'b1, 32'hFE000EE3, 32'h0000_2000, 1'b1, 1'b0);
        got = out_pkt;
        tests_run++;
        if (got.imm !== 32'hFFFFFFFC || got.rd !== 5'd0 || got.uses_rs1 !== 1'b1 ||
            got.uses_rs2 !== 1'b1 || got.writes_rd !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL beq got imm=%h rd=%0d u1=%b u2=%b wr=%b exp fffffffc/0/1/1/0",
                     got.imm, got.rd, got.uses_rs1, got.uses_rs2, got.writes_rd);
        end
        step(1'b1, 32'h123450B7, 32'h0000_2004, 1'b1, 1'b0);
        got = out_pkt;
        tests_run++;
        if (out_valid !== 1'b1 || got.imm !== 32'h12345000 || got.pc !== 32'h0000_2004) begin
            tests_failed++;
            $display("[TB] FAIL lui got valid=%b imm=%h pc=%h exp 1/12345000/00002004", out_valid, got.imm, got.pc);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        decode_pkt_t got;
        step(1'b1, 32'h00100113, 32'h0000_3000, 1'b0, 1'b0);
        step(1'b1, 32'h00200193, 32'h0000_3004, 1'b0, 1'b0);
        step(1'b1, 32'h00300213, 32'h0000_3008, 1'b0, 1'b0);
        got = out_pkt;
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || got.pc !== 32'h0000_3000) begin
            tests_failed++;
            $display("[TB] FAIL stall got in_ready=%b valid=%b pc=%h exp 0/1/00003000", in_ready, out_valid, got.pc);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'h00300213, 32'h0000_3008, 1'b1, 1'b0);
            got = out_pkt;
            tests_run++;
            if (out_valid !== 1'b1 || got.pc !== 32'h0000_3004 + 32'(k * 4) || out_pkt !== model_q[0]) begin
                tests_failed++;
                $display("[TB] FAIL drain%0d got valid=%b pc=%h exp pc=%h", k, out_valid, got.pc,
                         32'h0000_3004 + 32'(k * 4));
            end
            // keep presenting C only until it has been taken
            if (k == 1) break;
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL drain_empty got valid=%b exp=0", out_valid);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad_words [3];
        decode_pkt_t got;
        bad_words[0] = 32'h00003003;
        bad_words[1] = 32'h0000007F;
        bad_words[2] = 32'h40001033;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, bad_words[k], 32'h0000_4000 + 32'(k * 4), 1'b1, 1'b0);
            got = out_pkt;
            tests_run++;
            if (out_valid !== 1'b1 || got.illegal !== 1'b1 || got.writes_rd !== 1'b0 || out_pkt !== model_q[0]) begin
                tests_failed++;
                $display("[TB] FAIL illegal%0d got valid=%b ill=%b wr=%b pkt=%h exp pkt=%h", k,
                         out_valid, got.illegal, got.writes_rd, out_pkt, model_q[0]);
            end
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        step(1'b1, 32'h00100113, 32'h0000_5000, 1'b0, 1'b0);
        step(1'b1, 32'h00200193, 32'h0000_5004, 1'b0, 1'b0);
        step(1'b1, 32'h00300213, 32'h0000_5008, 1'b0, 1'b1);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush got valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++; $display("[TB] FAIL flush_quiet%0d got valid=%b exp=0", k, out_valid);
            end
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 32'h00700393, 32'h0000_6000, 1'b0, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL mid_prefill got valid=%b exp=1", out_valid);
        end
        rst = 1'b1;
        step(1'b1, 32'h00800413, 32'h0000_6004, 1'b0, 1'b0);
        rst = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || out_pkt !== '0) begin
            tests_failed++; $display("[TB] FAIL mid_reset got valid=%b pkt=%h exp 0/0", out_valid, out_pkt);
        end
        step(1'b1, 32'hFFF00493, 32'h0000_6008, 1'b1, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_pkt !== model_q[0]) begin
            tests_failed++; $display("[TB] FAIL post_reset got valid=%b pkt=%h exp=%h", out_valid, out_pkt, model_q[0]);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] pc;
        logic [31:0] ins;
        logic        iv;
        pc = 32'h0001_0000;
        ins = rand_instr();
        iv = 1'b0;
        for (int n = 0; n < 500; n++) begin
            tests_run++;
            if (out_valid !== (model_q.size() > 0) || in_ready !== (model_q.size() < 2)) begin
                tests_failed++;
                $display("[TB] FAIL rand_ctrl%0d got valid=%b in_ready=%b exp %b/%b", n, out_valid, in_ready,
                         model_q.size() > 0, model_q.size() < 2);
            end else if (model_q.size() > 0) begin
                tests_run++;
                if (out_pkt !== model_q[0]) begin
                    tests_failed++; $display("[TB] FAIL rand_pkt%0d got=%h exp=%h", n, out_pkt, model_q[0]);
                end
            end
            // a valid word stays put until taken, like a real fetch stage
            if (!(iv && in_valid && in_ready === 1'b0)) begin
                iv  = ($urandom_range(0, 3) != 0);
                ins = rand_instr();
                pc  = pc + 4;
            end
            step(iv, ins, pc, ($urandom_range(0, 2) != 0), ($urandom_range(0, 29) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_beq_lui();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
